// File: rtl/decoder_seq.sv
// Queued 3-to-8 decoder: codes enter a small FIFO and each one is driven on y
// as a registered one-hot word for HOLD_CYCLES enabled cycles.
module decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  output logic [7:0]               y,
  output logic                     y_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [7:0]    HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    y_q, y_d;
  logic          push, pop;
  logic [2:0]    head_code;

  // in_ready comes from the registered level only, so there is no path from in_valid.
  assign in_ready  = (level_q != FULL_LEVEL);
  assign push      = in_valid && in_ready;
  assign head_code = mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    y_d     = y_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        y_d = '0;
        if (enable && level_q != '0) begin
          pop     = 1'b1;
          code_d  = head_code;
          y_d     = 8'b1 << head_code;
          cnt_d   = HOLD_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!enable) begin
          // Gate the output but keep the counter and code for resumption.
          y_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
          y_d   = 8'b1 << code_q;
        end else if (level_q != '0) begin
          pop    = 1'b1;
          code_d = head_code;
          y_d    = 8'b1 << head_code;
          cnt_d  = HOLD_LOAD;
        end else begin
          y_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: the storage array has no reset; reset pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  assign y       = y_q;
  assign y_valid = (y_q != '0);
  assign level   = level_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios plus a randomized run
// scored against a queue-based model of accepted codes.
module tb_decoder_seq;

  localparam int H = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: codes accepted but not yet fully driven.
  logic [2:0] exp_q[$];
  int accepted = 0;
  int started  = 0;
  int run_cnt  = 0;

  decoder_seq #(.HOLD_CYCLES(H), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .in_valid(in_valid),
    .in_code (in_code),
    .in_ready(in_ready),
    .y       (y),
    .y_valid (y_valid),
    .level   (level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; returns at the falling edge, where outputs are sampled.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    @(negedge clk);
    cycle();
    check("rst_y", y, 8'h00);
    check("rst_yvalid", y_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    accepted = 0;
    started  = 0;
    run_cnt  = 0;
  endtask

  task automatic scoreboard(input logic en_prev, input int avail_prev);
    int code;
    check("sb_onehot", ((y & (y - 8'd1)) == 8'd0), 1'b1);
    check("sb_yvalid", y_valid, (y != 8'd0));
    if (!en_prev) check("sb_gated", y, 8'h00);
    if (y != 8'd0) begin
      code = 0;
      for (int b = 0; b < 8; b++) if (y[b]) code = b;
      if (exp_q.size() == 0) begin
        check("sb_unexpected", y, 8'h00);
      end else begin
        if (run_cnt == 0) started++;
        check("sb_order", code, exp_q[0]);
        run_cnt++;
        if (run_cnt == H) begin
          void'(exp_q.pop_front());
          run_cnt = 0;
        end
      end
    end else if (en_prev) begin
      check("sb_no_pause", run_cnt, 0);
      if (run_cnt == 0) check("sb_no_gap", avail_prev, 0);
    end
    check("sb_level", level, accepted - started);
  endtask

  task automatic rand_step();
    int   avail;
    logic acc;
    logic en;
    avail = accepted - started;
    acc   = in_valid && in_ready;
    en    = enable;
    cycle();
    if (acc) begin
      exp_q.push_back(in_code);
      accepted++;
    end
    scoreboard(en, avail);
  endtask

  initial begin
    logic [2:0] seq3[3];
    int budget;
    seq3 = '{3'd0, 3'd3, 3'd7};

    // Single code 5: one cycle latency then four cycles of 8'h20.
    apply_reset();
    enable   = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd5;
    cycle();
    in_valid = 1'b0;
    check("t1_latency_y", y, 8'h00);
    check("t1_latency_level", level, 1);
    for (int i = 0; i < H; i++) begin
      cycle();
      check("t1_hold", y, 8'h20);
    end
    cycle();
    check("t1_end_y", y, 8'h00);
    check("t1_end_level", level, 0);

    // Codes 0,3,7 back-to-back: contiguous words, no idle gap.
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 15; k++) begin
      in_valid = (k < 3);
      in_code  = (k < 3) ? seq3[k] : 3'd0;
      cycle();
      if (k >= 1 && k <= 3 * H) check("t2_seq", y, 8'b1 << seq3[(k - 1) / H]);
      else                      check("t2_seq", y, 8'h00);
    end
    check("t2_level", level, 0);

    // Fill with enable low, fifth code held off until a pop frees a slot.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i);
      check("t3_ready_fill", in_ready, 1'b1);
      cycle();
    end
    in_code = 3'd4;
    check("t3_full_ready", in_ready, 1'b0);
    check("t3_full_level", level, 4);
    check("t3_full_y", y, 8'h00);
    cycle();
    check("t3_still_full", level, 4);
    enable = 1'b1;
    cycle();
    check("t3_pop_y", y, 8'h01);
    check("t3_pop_level", level, 3);
    check("t3_pop_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("t3_push5_level", level, 4);
    check("t3_hold_y", y, 8'h01);
    for (int j = 2; j < 5 * H; j++) begin
      cycle();
      check("t3_drain", y, 8'b1 << (j / H));
    end
    cycle();
    check("t3_end_y", y, 8'h00);
    check("t3_end_level", level, 0);

    // Code 2 paused by enable for three cycles, then resumes for its last two.
    apply_reset();
    enable   = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd2;
    cycle();
    in_valid = 1'b0;
    check("t4_latency", y, 8'h00);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t4_first", y, 8'h04);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_gap_y", y, 8'h00);
      check("t4_gap_yvalid", y_valid, 1'b0);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t4_resume", y, 8'h04);
    end
    cycle();
    check("t4_end", y, 8'h00);

    // Asynchronous reset mid-drive with two codes queued.
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i + 1);
      cycle();
    end
    in_valid = 1'b0;
    check("t5_pre_y", y, 8'h02);
    check("t5_pre_level", level, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_y", y, 8'h00);
    check("t5_async_level", level, 0);
    check("t5_async_ready", in_ready, 1'b1);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t5_no_stale_y", y, 8'h00);
      check("t5_no_stale_level", level, 0);
    end
    in_valid = 1'b1;
    in_code  = 3'd6;
    cycle();
    in_valid = 1'b0;
    check("t5_new_latency", y, 8'h00);
    cycle();
    check("t5_new_y", y, 8'h40);

    // Randomized pushes and enable toggling against the queue model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 9) < 7);
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 3'($urandom_range(0, 7));
      rand_step();
    end
    enable   = 1'b1;
    in_valid = 1'b0;
    budget   = 200;
    while ((exp_q.size() != 0 || run_cnt != 0) && budget > 0) begin
      rand_step();
      budget--;
    end
    check("rand_drained", (exp_q.size() == 0 && run_cnt == 0), 1'b1);
    check("rand_accepted", (accepted > 20), 1'b1);
    rand_step();
    check("rand_end_y", y, 8'h00);
    check("rand_end_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
